// File: rtl/disp_pkg.sv
// Shared types and helpers for the multiplexed 7-segment display scanner.
package disp_pkg;

    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam int         MAX_DIGITS = 8;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // Observation point for checkers: the scan FSM and its derived controls.
    typedef struct packed {
        scan_state_t state;
        logic        lit;
        logic        frame_end;
    } scan_dbg_t;

    // Active-low one-hot digit select; indices at or beyond n stay dark.
    function automatic logic [MAX_DIGITS-1:0] anode_onehot_n(input logic [2:0] idx, input int n);
        logic [MAX_DIGITS-1:0] r;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            r[i] = !((i == int'(idx)) && (i < n));
        end
        return r;
    endfunction

endpackage

// File: rtl/display_scanner_decoder.sv
// 4-bit hex to 7-segment decoder, active-low outputs ordered {g,f,e,d,c,b,a}.
module seg7_decoder (
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = 7'h7F;
        case ({a, b, c, d})
            4'h0: seg_n = 7'b1000000;
            4'h1: seg_n = 7'b1111001;
            4'h2: seg_n = 7'b0100100;
            4'h3: seg_n = 7'b0110000;
            4'h4: seg_n = 7'b0011001;
            4'h5: seg_n = 7'b0010010;
            4'h6: seg_n = 7'b0000010;
            4'h7: seg_n = 7'b1111000;
            4'h8: seg_n = 7'b0000000;
            4'h9: seg_n = 7'b0010000;
            4'hA: seg_n = 7'b0001000;
            4'hB: seg_n = 7'b0000011;
            4'hC: seg_n = 7'b1000110;
            4'hD: seg_n = 7'b0100001;
            4'hE: seg_n = 7'b0000110;
            4'hF: seg_n = 7'b0001110;
            default: seg_n = 7'h7F;
        endcase
    end

endmodule

// File: rtl/display_scanner.sv
// Scans a double-buffered digit word across N common-anode digits with a
// blanking guard at the start of every slot; new words land only at frame end.
module display_scanner
    import disp_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] data_in,
    input  logic [N_DIGITS-1:0]   digit_en,
    output logic                  pending,
    output logic                  load_ack,
    output logic [N_DIGITS-1:0]   anode_n,
    output logic [6:0]            seg_n
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE_SHOW = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(N_DIGITS - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    scan_state_t           state_q, state_d;
    logic [4*N_DIGITS-1:0] active_q, shadow_q;
    logic                  pending_q, ack_q;
    logic                  slot_end;
    logic [3:0]            nibble;
    logic [6:0]            dec_seg_n;
    scan_dbg_t             dbg;

    always_comb begin
        slot_end = (cnt_q == CNT_LAST);
        cnt_d    = slot_end ? '0 : cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        state_d = state_q;
        case (state_q)
            BLANK: if (cnt_q == CNT_PRE_SHOW) state_d = SHOW;
            SHOW:  if (slot_end)              state_d = BLANK;
            default: state_d = BLANK;
        endcase
    end

    always_comb begin
        dbg           = '0;
        dbg.state     = state_q;
        dbg.frame_end = slot_end && (idx_q == IDX_LAST);
        dbg.lit       = !rst && (state_q == SHOW) && digit_en[idx_q];
    end

    // Handshake: load is a one-cycle write strobe with no back-pressure; the
    // word is parked in shadow (pending=1) and load_ack pulses for one cycle
    // once it is committed at a frame boundary. A load landing on the boundary
    // bypasses shadow and is committed directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            state_q   <= BLANK;
            active_q  <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            state_q <= state_d;
            ack_q   <= 1'b0;
            if (load) begin
                shadow_q <= data_in;
            end
            if (dbg.frame_end && load) begin
                active_q  <= data_in;
                pending_q <= 1'b0;
                ack_q     <= 1'b1;
            end else if (dbg.frame_end && pending_q) begin
                active_q  <= shadow_q;
                pending_q <= 1'b0;
                ack_q     <= 1'b1;
            end else if (load) begin
                pending_q <= 1'b1;
            end
        end
    end

    assign nibble = active_q[idx_q*4 +: 4];

    seg7_decoder u_dec (
        .a     (nibble[3]),
        .b     (nibble[2]),
        .c     (nibble[1]),
        .d     (nibble[0]),
        .seg_n (dec_seg_n)
    );

    always_comb begin
        anode_n = '1;
        seg_n   = SEG_OFF;
        if (dbg.lit) begin
            anode_n = N_DIGITS'(anode_onehot_n(3'(idx_q), N_DIGITS));
            seg_n   = dec_seg_n;
        end
    end

    assign pending  = pending_q;
    assign load_ack = ack_q;

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner with N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_display_scanner;

    localparam int N_DIGITS     = 4;
    localparam int REFRESH_DIV  = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int FRAME        = N_DIGITS * REFRESH_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  digit_en;
    logic        pending;
    logic        load_ack;
    logic [3:0]  anode_n;
    logic [6:0]  seg_n;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int abs_cyc  = 0;

    logic [15:0] exp_active;
    logic        exp_pend;
    logic        exp_ack;
    logic [3:0]  exp_q[$];

    display_scanner #(
        .N_DIGITS     (N_DIGITS),
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .data_in  (data_in),
        .digit_en (digit_en),
        .pending  (pending),
        .load_ack (load_ack),
        .anode_n  (anode_n),
        .seg_n    (seg_n)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] dec(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, abs_cyc);
        end
    endtask

    // One clock: sample on the falling edge, then advance past the rising edge.
    task automatic tick();
        int         t;
        int         slot;
        int         c;
        logic [3:0] exp_an;
        logic [6:0] exp_sg;
        @(negedge clk);
        t      = cyc % FRAME;
        slot   = t / REFRESH_DIV;
        c      = t % REFRESH_DIV;
        exp_an = 4'hF;
        exp_sg = 7'h7F;
        if (!rst && c >= BLANK_CYCLES && digit_en[slot]) begin
            exp_an[slot] = 1'b0;
            exp_sg       = dec(exp_active[slot*4 +: 4]);
        end
        chk("anode_n", 16'(anode_n), 16'(exp_an));
        chk("seg_n", 16'(seg_n), 16'(exp_sg));
        chk("pending", 16'(pending), 16'(exp_pend));
        chk("load_ack", 16'(load_ack), 16'(exp_ack));
        if (!rst) begin
            if (abs_cyc < 64 && c == BLANK_CYCLES) begin
                if (exp_q.size() > 0) chk("scan_order", 16'(anode_n), 16'(exp_q.pop_front()));
            end
            case (abs_cyc)
                0:   chk("reset_blank_anode", 16'(anode_n), 16'h000F);
                2:   begin
                         chk("reset_digit0_anode", 16'(anode_n), 16'h000E);
                         chk("reset_digit0_seg", 16'(seg_n), 16'h0040);
                     end
                32:  chk("wrap_blank_anode", 16'(anode_n), 16'h000F);
                34:  chk("wrap_digit0_anode", 16'(anode_n), 16'h000E);
                75:  chk("load_sets_pending", 16'(pending), 16'h0001);
                96:  chk("commit_ack", 16'(load_ack), 16'h0001);
                97:  chk("ack_single_cycle", 16'(load_ack), 16'h0000);
                98:  chk("digit0_shows_1", 16'(seg_n), 16'h0079);
                122: begin
                         chk("digit3_anode", 16'(anode_n), 16'h0007);
                         chk("digit3_shows_4", 16'(seg_n), 16'h0019);
                     end
                162: chk("overwrite_shows_2", 16'(seg_n), 16'h0024);
                224: chk("collision_pending_clear", 16'(pending), 16'h0000);
                226: chk("collision_shows_5", 16'(seg_n), 16'h0012);
                276: begin
                         chk("dark_slot_anode", 16'(anode_n), 16'h000F);
                         chk("dark_slot_seg", 16'(seg_n), 16'h007F);
                     end
                332: chk("no_ack_after_reset", 16'(load_ack), 16'h0000);
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        cyc++;
        abs_cyc++;
    endtask

    task automatic do_load(input logic [15:0] word);
        load    = 1'b1;
        data_in = word;
        tick();
        load    = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        load       = 1'b0;
        data_in    = '0;
        digit_en   = 4'hF;
        exp_active = '0;
        exp_pend   = 1'b0;
        exp_ack    = 1'b0;
        exp_q      = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE, 4'hD, 4'hB, 4'h7};

        repeat (3) tick();
        rst     = 1'b0;
        cyc     = 0;
        abs_cyc = 0;

        // Two full frames of plain scanning with the reset word.
        repeat (64) tick();

        // Mid-frame load, committed at the next frame boundary.
        repeat (10) tick();
        do_load(16'h4321);
        exp_pend = 1'b1;
        repeat (21) tick();
        exp_pend   = 1'b0;
        exp_ack    = 1'b1;
        exp_active = 16'h4321;
        tick();
        exp_ack = 1'b0;
        repeat (31) tick();

        // Two loads in one frame: only the last is committed.
        repeat (5) tick();
        do_load(16'h1111);
        exp_pend = 1'b1;
        repeat (14) tick();
        do_load(16'h2222);
        repeat (11) tick();
        exp_pend   = 1'b0;
        exp_ack    = 1'b1;
        exp_active = 16'h2222;
        tick();
        exp_ack = 1'b0;
        repeat (31) tick();

        // Load on the boundary edge beats the older shadow word.
        repeat (3) tick();
        do_load(16'hAAAA);
        exp_pend = 1'b1;
        repeat (27) tick();
        do_load(16'h5555);
        exp_pend   = 1'b0;
        exp_ack    = 1'b1;
        exp_active = 16'h5555;
        tick();
        exp_ack = 1'b0;
        repeat (31) tick();

        // Digit 2 disabled, then reset with a word still pending.
        digit_en = 4'b1011;
        repeat (36) tick();
        do_load(16'h9999);
        exp_pend = 1'b1;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        cyc        = 0;
        exp_pend   = 1'b0;
        exp_active = '0;
        repeat (40) tick();

        chk("scan_queue_drained", 16'(exp_q.size()), 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/display_scanner.md
Name: display_scanner

Overview:
Time-multiplexes one 4-bit to 7-segment decoder across N common-anode digits of the board display. Holds a double-buffered digit word. A new word is committed only at a frame boundary, so the display never tears. Each digit slot inserts a blanking guard to suppress ghosting. The block sits between lab control logic, which writes the value, and the display pins.

Parameters:
N_DIGITS, 4, number of multiplexed digits (2..8)
REFRESH_DIV, 50000, clock cycles per digit slot (>= 4)
BLANK_CYCLES, 16, leading cycles of each slot with all anodes off (1 .. REFRESH_DIV-2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
load  in  1  single-cycle request to write data_in
data_in  in  4*N_DIGITS  digit nibbles; digit k = data_in[4k+3:4k], bit 3 = decoder input A (MSB)
digit_en  in  N_DIGITS  per-digit enable, sampled live; 0 = digit dark
pending  out  1  shadow holds an uncommitted word
load_ack  out  1  one-cycle pulse: word committed to display
anode_n  out  N_DIGITS  active-low digit select
seg_n  out  7  active-low segments {g,f,e,d,c,b,a}

Behaviour:
- Clocking: one clock, clk; reset rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: slot counter cnt=0; digit index idx=0; state BLANK; active word=0; shadow=0; pending=0; load_ack=0. While rst is high, anode_n is all 1s and seg_n=7'h7F.
- Slot timing: cnt runs 0..REFRESH_DIV-1 and then wraps to 0.
  - On wrap, idx increments and wraps from N_DIGITS-1 to 0.
  - Frame length is N_DIGITS*REFRESH_DIV cycles.
- State machine (per slot):
  - BLANK while cnt < BLANK_CYCLES. anode_n all 1s, seg_n=7'h7F.
  - SHOW while cnt >= BLANK_CYCLES. anode_n[idx]=0, all other bits 1.
  - In SHOW, seg_n = decoder(active[idx]) if digit_en[idx]=1; otherwise anode_n is all 1s and seg_n=7'h7F.
  - Transitions: BLANK->SHOW when cnt reaches BLANK_CYCLES; SHOW->BLANK on slot wrap.
- Outputs: anode_n and seg_n are combinational functions of registered idx, cnt and active only. Valid in the cycle the registers change.
- Decoder: the existing 4-bit segment decoder is used unchanged, with inputs A,B,C,D = nibble[3:0].
- Load handshake:
  - load=1 writes data_in into shadow and sets pending=1.
  - A load while pending=1 overwrites shadow; only the last word is committed.
- Frame boundary commit:
  - The frame boundary is the edge ending cnt=REFRESH_DIV-1 with idx=N_DIGITS-1.
  - On that edge, if pending=1: active<=shadow, pending<=0.
  - load_ack=1 for exactly the next cycle (cnt=0, idx=0).
- Simultaneous load and boundary: data_in is committed directly (incoming wins over shadow). pending ends 0 and load_ack pulses.
- No pending at boundary: active is unchanged and no ack.
- Reset mid-frame: state returns to reset values on the next edge. A pending word is discarded and no ack is issued.

Decomposition:
- Package disp_pkg:
  - SEG_OFF = 7'h7F
  - scan_state_t enum {BLANK, SHOW}
  - function anode_onehot_n(idx, n)
- Sub-module: the existing 4-bit segment decoder, one instance fed by the muxed nibble.
- The counter/index logic is small enough to stay inline.
- cnt width = $clog2(REFRESH_DIV); idx width = $clog2(N_DIGITS), minimum 1.

Test Plan:
All scenarios use N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset: hold rst 3 cycles, release -> anode_n=4'hF and seg_n=7'h7F for cycles 0-1; from cycle 2, anode_n=4'hE and seg_n=decoder(0000)=7'b1000000; pending=0.
- Scan order: run 64 cycles with digit_en=4'hF -> anode_n steps E,D,B,7 every 8 cycles, each preceded by 2 all-off cycles; wraps to E at cycle 32.
- Load mid-frame: pulse load with data_in=16'h4321 at cycle 10 -> pending=1 from cycle 11; digits still show 0 until cycle 32; load_ack=1 only in cycle 32; then digit0 shows decoder(0001) and digit3 decoder(0100).
- Overwrite: load 16'h1111 at cycle 5, then load 16'h2222 at cycle 20 -> single ack at cycle 32; active=16'h2222.
- Boundary collision: pending=1 with shadow=16'hAAAA, and load with 16'h5555 in cycle 31 -> active=16'h5555, ack in cycle 32, pending=0.
- Blank and reset: digit_en=4'b1011 -> slot 2 shows anode_n=4'hF, seg_n=7'h7F throughout; asserting rst with pending=1 -> pending=0, no load_ack, active=0.
